// File: rtl/isop_fir_mac_if.sv
// Sample handshake bundle for isop_fir_mac.
// Input valid/ready, output valid pulse and busy status.
interface isop_fir_mac_if #(
  parameter int DIN_W  = 8,
  parameter int DOUT_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DIN_W-1:0]  in_data;
  logic                     out_valid;
  logic signed [DOUT_W-1:0] out_data;
  logic                     busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/isop_fir_mac.sv
// Symmetric ISOP FIR, one time-shared MAC, rounded output.
// Define ISOP_SAT_EN to clamp the output instead of wrapping it.
module isop_fir_mac #(
  parameter int DIN_W  = 8,
  parameter int DOUT_W = 8,
  parameter int COEF_W = 26,
  parameter int NTAPS  = 15,
  parameter int FRAC   = 23,
  parameter int ACC_W  = 40,
  parameter logic [((NTAPS+1)/2)*COEF_W-1:0] COEFS = {
    26'sd14901461, -26'sd3125632, -26'sd868335, 26'sd1504341,
    -26'sd1038076, 26'sd477137, -26'sd157159, 26'sd54038
  }
) (
  input logic clk,
  input logic rst,
  isop_fir_mac_if.slave s
);
  localparam int H  = (NTAPS + 1) / 2;
  localparam int IW = $clog2(NTAPS);
  localparam int PW = DIN_W + 1 + COEF_W;
  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'(1) << (FRAC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                   r_state;
  logic signed [DIN_W-1:0]  r_x [NTAPS];
  logic signed [ACC_W-1:0]  r_acc;
  logic [IW-1:0]            r_k;
  logic                     r_rdy;
  logic                     r_busy;
  logic                     r_ov;
  logic signed [DOUT_W-1:0] r_od;

  logic signed [DIN_W-1:0]  w_xa;
  logic signed [DIN_W-1:0]  w_xb;
  logic signed [COEF_W-1:0] w_coef;
  logic                     w_last;
  logic signed [DIN_W:0]    w_psum;
  logic signed [DIN_W:0]    w_pre;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_r;
  logic signed [DOUT_W-1:0] w_out;

  assign w_xa   = r_x[r_k];
  assign w_xb   = r_x[IW'(NTAPS - 1) - r_k];
  assign w_coef = COEFS[r_k*COEF_W +: COEF_W];
  assign w_last = (r_k == IW'(H - 1));

  // Folded pair sum; the centre tap has no partner.
  assign w_psum = {w_xa[DIN_W-1], w_xa}
                + {w_xb[DIN_W-1], w_xb};
  assign w_pre  = w_last ? {w_xa[DIN_W-1], w_xa} : w_psum;
  assign w_prod = PW'(w_pre) * PW'(w_coef);
  assign w_ext  = ACC_W'(w_prod);

  assign w_rnd  = r_acc + HALF;
  assign w_r    = w_rnd >>> FRAC;

`ifdef ISOP_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV =
    ACC_W'((1 << (DOUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  assign w_out = (w_r > MAXV) ? DOUT_W'(MAXV) :
                 (w_r < MINV) ? DOUT_W'(MINV) :
                 DOUT_W'(w_r);
`else
  assign w_out = DOUT_W'(w_r);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      for (int i = 0; i < NTAPS; i++) r_x[i] <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_rdy   <= 1'b1;
      r_busy  <= 1'b0;
      r_ov    <= 1'b0;
      r_od    <= '0;
    end else begin
      r_ov <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (s.in_valid) begin
            for (int i = NTAPS - 1; i > 0; i--)
              r_x[i] <= r_x[i-1];
            r_x[0]  <= s.in_data;
            r_acc   <= '0;
            r_k     <= '0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_ext;
          r_k   <= r_k + IW'(1);
          if (w_last) r_state <= S_OUT;
        end
        S_OUT: begin
          r_od    <= w_out;
          r_ov    <= 1'b1;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s.in_ready  = r_rdy;
  assign s.busy      = r_busy;
  assign s.out_valid = r_ov;
  assign s.out_data  = r_od;
endmodule
